multicycle_main_fsm_controlpath_risc_v: RTL and testbench
=========================================================

Name: multicycle_main_fsm_controlpath_risc_v

Overview:
- Main control FSM for the multicycle RV32I datapath, directly upstream of the ALU decoder.
- Sequences fetch, decode, execute, memory and writeback per instruction; drives datapath mux selects and write enables.
- Produces the 2-bit ALUOp consumed by the ALU decoder, and the immediate-format select.
- Handles lw, sw, R-type, I-type ALU, beq and jal, with a memory-ready handshake on instruction and data accesses.

Parameters:
- STATE_W, 4, width of state register and of debug port state_o.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- op  input  7  opcode from instruction register; stable from DECODE until return to FETCH.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 PC, 1 ALUOut.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  instruction/OldPC register enable.
- ResultSrc  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  output  2  00 rs2, 01 ImmExt, 10 constant 4.
- RegWrite  output  1  register file write enable.
- ALUOp  output  2  to ALU decoder: 00 add, 01 sub/compare, 10 funct-decoded.
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J.
- state_o  output  STATE_W  current state, debug only.

Behaviour:
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11. Codes 12-15 are unused and go to FETCH on the next edge.
- Reset: on a clk edge with rst_n=0, state becomes FETCH.
- While rst_n=0, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0. All other outputs are the FETCH values.
- Outputs are combinational from state, plus op (ImmSrc only) and zero/mem_ready where stated. Unlisted outputs are 0.
- Internal PCUpdate and Branch signals: PCWrite = PCUpdate | (Branch & zero).
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=mem_ready.
  - Goes to DECODE when mem_ready=1; otherwise holds, with no IR or PC update.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - lw(0000011) or sw(0100011) -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - beq(1100011) -> BEQ.
  - jal(1101111) -> JAL.
  - Any other opcode: see Optional Feature.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB on mem_ready, else holds.
- MEMWB: ResultSrc=01, RegWrite=1. -> FETCH.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemWrite=1, held for every cycle in the state.
  - Goes to FETCH on mem_ready, else holds.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. -> ALUWB.
- ImmSrc is decoded from op in every state:
  - lw / 0010011 -> 00.
  - sw -> 01.
  - beq -> 10.
  - jal -> 11.
  - otherwise 00.
- Cycle counts with mem_ready held high: lw 5, sw 4, R/I 4, beq 3, jal 4.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset asserted mid-instruction abandons it. State is FETCH after that edge; no write strobe is asserted while rst_n=0.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Unsupported opcode in DECODE -> TRAP.
  - TRAP asserts all enables 0 and holds until reset.
  - Extra output illegal_op (1 bit) is 1 only in TRAP and is 0 during reset.
- Not defined:
  - Unsupported opcode in DECODE -> FETCH (treated as nop, PC already advanced).
  - State code 11 is unused and behaves like 12-15.
  - The illegal_op port does not exist.

Test Plan:
- Reset: rst_n=0 for 2 cycles with mem_ready=1 -> state_o=0, all write enables 0. Release -> IRWrite=PCWrite=1 in the first cycle, state_o=1 next.
- lw with op=0000011, mem_ready low 2 cycles in MEMREAD -> state sequence 0,1,2,3,3,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 there.
- sw with op=0100011, mem_ready=1 -> states 0,1,2,5,0; MemWrite=1 exactly 1 cycle; AdrSrc=1; ImmSrc=01.
- R-type op=0110011 -> ALUOp=10 and ALUSrcB=00 in state 6; RegWrite in state 8; I-type op=0010011 -> ALUSrcB=01 in state 7.
- beq op=1100011: zero=1 -> PCWrite=1 in state 9, ALUOp=01; zero=0 -> PCWrite=0; both return to 0.
- op=1111111 -> with ILLEGAL_OP_TRAP_EN: state 11, illegal_op=1, held until rst_n=0; without the macro: DECODE->FETCH, no write strobes.

Source files
------------

// File: rtl/multicycle_main_fsm_controlpath_risc_v.sv
//==============================================================================
// Module      : multicycle_main_fsm_controlpath_risc_v
// Description : Main control FSM for the multicycle RV32I datapath.
//               Optional macro ILLEGAL_OP_TRAP_EN adds the TRAP state and illegal_op.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_main_fsm_controlpath_risc_v #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ImmSrc,
    output logic [STATE_W-1:0] state_o
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
`ifdef ILLEGAL_OP_TRAP_EN
    localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);
`endif

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_out_state;
    logic               w_pcupdate;
    logic               w_branch;
    logic               w_irwrite;
    logic               w_memwrite;
    logic               w_regwrite;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXECUTER;
                    c_OP_I:           w_next = S_EXECUTEI;
                    c_OP_BEQ:         w_next = S_BEQ;
                    c_OP_JAL:         w_next = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:          w_next = S_TRAP;
`else
                    default:          w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // During reset the outputs present the FETCH decode regardless of the stale state.
    assign w_out_state = rst_n ? r_state : S_FETCH;

    always_comb begin
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        case (w_out_state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_irwrite  = mem_ready;
                w_pcupdate = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    w_regwrite = 1'b1;
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BEQ: ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite  = rst_n & (w_pcupdate | (w_branch & zero));
    assign IRWrite  = rst_n & w_irwrite;
    assign MemWrite = rst_n & w_memwrite;
    assign RegWrite = rst_n & w_regwrite;
    assign state_o  = r_state;

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op = rst_n & (r_state == S_TRAP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_fsm_controlpath_risc_v.sv
//==============================================================================
// Module      : tb_multicycle_main_fsm_controlpath_risc_v
// Description : Directed self-checking bench for the multicycle main control FSM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multicycle_main_fsm_controlpath_risc_v;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state_o;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_main_fsm_controlpath_risc_v #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .state_o(state_o)
`ifdef ILLEGAL_OP_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one clock edge; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0; zero = 1'b0;
        @(negedge clk);
        tick(); tick();
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin errors++; $display("FAIL reset_enables got=%b exp=0000", {PCWrite, MemWrite, IRWrite, RegWrite}); end
        checks++; if ({ALUSrcB, ResultSrc, AdrSrc} !== 5'b10100) begin errors++; $display("FAIL reset_fetch_sel got=%b exp=10100", {ALUSrcB, ResultSrc, AdrSrc}); end
        rst_n = 1'b1;
        #1;
        checks++; if ({IRWrite, PCWrite} !== 2'b11) begin errors++; $display("FAIL release_fetch_wr got=%b exp=11", {IRWrite, PCWrite}); end
        tick();
        checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL release_decode got=%0d exp=1", state_o); end
        tick();
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL op0_back_fetch got=%0d exp=0", state_o); end
    endtask

    task automatic test_fetch_stall();
        mem_ready = 1'b0;
        #1;
        checks++; if ({IRWrite, PCWrite} !== 2'b00) begin errors++; $display("FAIL fetch_stall_wr got=%b exp=00", {IRWrite, PCWrite}); end
        tick();
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL fetch_stall_hold got=%0d exp=0", state_o); end
        mem_ready = 1'b1;
    endtask

    task automatic test_lw();
        op = 7'b0000011; mem_ready = 1'b1;
        #1;
        checks++; if (ImmSrc !== 2'b00) begin errors++; $display("FAIL lw_immsrc got=%b exp=00", ImmSrc); end
        tick();
        checks++; if ({state_o, ALUSrcA, ALUSrcB} !== {4'd1, 2'b01, 2'b01}) begin errors++; $display("FAIL lw_decode got=%0d/%b/%b", state_o, ALUSrcA, ALUSrcB); end
        tick();
        checks++; if ({state_o, ALUSrcA, ALUSrcB} !== {4'd2, 2'b10, 2'b01}) begin errors++; $display("FAIL lw_memadr got=%0d/%b/%b", state_o, ALUSrcA, ALUSrcB); end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++; if ({state_o, AdrSrc, RegWrite} !== {4'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL lw_memread got=%0d/%b/%b exp=3/1/0", state_o, AdrSrc, RegWrite); end
        tick();
        checks++; if (state_o !== 4'd3) begin errors++; $display("FAIL lw_stall1 got=%0d exp=3", state_o); end
        tick();
        checks++; if (state_o !== 4'd3) begin errors++; $display("FAIL lw_stall2 got=%0d exp=3", state_o); end
        mem_ready = 1'b1;
        tick();
        checks++; if ({state_o, RegWrite, ResultSrc} !== {4'd4, 1'b1, 2'b01}) begin errors++; $display("FAIL lw_memwb got=%0d/%b/%b exp=4/1/01", state_o, RegWrite, ResultSrc); end
        tick();
        checks++; if ({state_o, RegWrite} !== {4'd0, 1'b0}) begin errors++; $display("FAIL lw_return got=%0d/%b exp=0/0", state_o, RegWrite); end
    endtask

    task automatic test_sw();
        op = 7'b0100011;
        tick(); tick();
        checks++; if ({state_o, MemWrite} !== {4'd2, 1'b0}) begin errors++; $display("FAIL sw_memadr got=%0d/%b exp=2/0", state_o, MemWrite); end
        tick();
        checks++; if ({state_o, MemWrite, AdrSrc, ImmSrc} !== {4'd5, 1'b1, 1'b1, 2'b01}) begin errors++; $display("FAIL sw_memwrite got=%0d/%b/%b/%b exp=5/1/1/01", state_o, MemWrite, AdrSrc, ImmSrc); end
        tick();
        checks++; if ({state_o, MemWrite} !== {4'd0, 1'b0}) begin errors++; $display("FAIL sw_return got=%0d/%b exp=0/0", state_o, MemWrite); end
    endtask

    task automatic test_rtype();
        op = 7'b0110011;
        tick(); tick();
        checks++; if ({state_o, ALUOp, ALUSrcA, ALUSrcB} !== {4'd6, 2'b10, 2'b10, 2'b00}) begin errors++; $display("FAIL r_exec got=%0d/%b/%b/%b exp=6/10/10/00", state_o, ALUOp, ALUSrcA, ALUSrcB); end
        tick();
        checks++; if ({state_o, RegWrite, ResultSrc} !== {4'd8, 1'b1, 2'b00}) begin errors++; $display("FAIL r_aluwb got=%0d/%b/%b exp=8/1/00", state_o, RegWrite, ResultSrc); end
        tick();
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL r_return got=%0d exp=0", state_o); end
    endtask

    task automatic test_itype();
        op = 7'b0010011;
        tick(); tick();
        checks++; if ({state_o, ALUOp, ALUSrcB, ImmSrc} !== {4'd7, 2'b10, 2'b01, 2'b00}) begin errors++; $display("FAIL i_exec got=%0d/%b/%b/%b exp=7/10/01/00", state_o, ALUOp, ALUSrcB, ImmSrc); end
        tick();
        checks++; if ({state_o, RegWrite} !== {4'd8, 1'b1}) begin errors++; $display("FAIL i_aluwb got=%0d/%b exp=8/1", state_o, RegWrite); end
        tick();
    endtask

    task automatic test_beq(input logic z);
        op = 7'b1100011; zero = z;
        #1;
        checks++; if (ImmSrc !== 2'b10) begin errors++; $display("FAIL beq_immsrc got=%b exp=10", ImmSrc); end
        tick(); tick();
        checks++; if ({state_o, ALUOp, PCWrite, RegWrite} !== {4'd9, 2'b01, z, 1'b0}) begin errors++; $display("FAIL beq_z%0d got=%0d/%b/%b/%b exp=9/01/%b/0", z, state_o, ALUOp, PCWrite, RegWrite, z); end
        tick();
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL beq_return got=%0d exp=0", state_o); end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        op = 7'b1101111;
        tick(); tick();
        checks++; if ({state_o, PCWrite, ALUSrcA, ALUSrcB, ImmSrc} !== {4'd10, 1'b1, 2'b01, 2'b10, 2'b11}) begin errors++; $display("FAIL jal_state got=%0d/%b/%b/%b/%b exp=10/1/01/10/11", state_o, PCWrite, ALUSrcA, ALUSrcB, ImmSrc); end
        tick();
        checks++; if ({state_o, RegWrite} !== {4'd8, 1'b1}) begin errors++; $display("FAIL jal_aluwb got=%0d/%b exp=8/1", state_o, RegWrite); end
        tick();
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL jal_return got=%0d exp=0", state_o); end
    endtask

    task automatic test_reset_mid();
        op = 7'b0000011;
        tick(); tick(); tick(); tick();
        checks++; if ({state_o, RegWrite} !== {4'd4, 1'b1}) begin errors++; $display("FAIL mid_pre got=%0d/%b exp=4/1", state_o, RegWrite); end
        rst_n = 1'b0;
        #1;
        checks++; if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin errors++; $display("FAIL mid_enables got=%b exp=0000", {PCWrite, MemWrite, IRWrite, RegWrite}); end
        tick();
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL mid_state got=%0d exp=0", state_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        op = 7'b1111111;
        tick();
        checks++; if ({state_o, PCWrite, MemWrite, IRWrite, RegWrite} !== {4'd1, 4'b0000}) begin errors++; $display("FAIL ill_decode got=%0d/%b exp=1/0000", state_o, {PCWrite, MemWrite, IRWrite, RegWrite}); end
        tick();
`ifdef ILLEGAL_OP_TRAP_EN
        checks++; if ({state_o, illegal_op, PCWrite, MemWrite, IRWrite, RegWrite} !== {4'd11, 1'b1, 4'b0000}) begin errors++; $display("FAIL ill_trap got=%0d/%b/%b exp=11/1/0000", state_o, illegal_op, {PCWrite, MemWrite, IRWrite, RegWrite}); end
        tick(); tick();
        checks++; if ({state_o, illegal_op} !== {4'd11, 1'b1}) begin errors++; $display("FAIL ill_hold got=%0d/%b exp=11/1", state_o, illegal_op); end
        rst_n = 1'b0;
        #1;
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_rst_flag got=%b exp=0", illegal_op); end
        tick();
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL ill_rst_state got=%0d exp=0", state_o); end
        rst_n = 1'b1;
`else
        checks++; if ({state_o, MemWrite, RegWrite} !== {4'd0, 2'b00}) begin errors++; $display("FAIL ill_nop got=%0d/%b%b exp=0/00", state_o, MemWrite, RegWrite); end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_lw();
        test_sw();
        test_rtype();
        test_itype();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal();
        test_reset_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
